// File: rtl/cod_pkg.sv
// Shared constants and state encoding for the priority encoder.
package cod_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_t;

endpackage

// File: rtl/cod_prio_busca.sv
// Combinational winner search: fixed highest-index or round-robin descending
// from ptr, plus a popcount-based multi flag from the same sample.
module cod_prio_busca
    import cod_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         multi
);

    int unsigned cnt;
    int          j;
    logic [W-1:0] pos;

    // Winner search and popcount over the current request sample.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cnt   = 0;
        j     = 0;
        pos   = '0;
        if (mode == 1'(MODE_RR)) begin
            // Visit ptr, ptr-1, ..., 0, N-1, ...; first set bit wins.
            for (int k = 0; k < int'(N); k++) begin
                j = int'(ptr) - k;
                if (j < 0) begin
                    j = j + int'(N);
                end
                pos = W'(j);
                if (!found && req[pos]) begin
                    found = 1'b1;
                    idx   = pos;
                end
            end
        end else begin
            // Ascending scan so the highest set index is the last one kept.
            for (int i = 0; i < int'(N); i++) begin
                pos = W'(i);
                if (req[pos]) begin
                    found = 1'b1;
                    idx   = pos;
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            cnt = cnt + 32'(req[i]);
        end
        multi = (cnt > 1);
    end

endmodule

// File: rtl/cod_prioridade_rr.sv
// Registered priority encoder with valid/ready output and optional round-robin.
module cod_prioridade_rr
    import cod_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = $clog2(N),
    parameter int unsigned MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] grant,
    output logic         multi
);

    localparam logic [W-1:0] PtrInit = W'(N - 1);
    localparam logic         ModeRr  = (MODE == MODE_RR);

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         multi_q, multi_d;
    logic         capture;

    logic [W-1:0] win_idx;
    logic         win_found;
    logic         win_multi;

    cod_prio_busca #(
        .N (N),
        .W (W)
    ) u_busca (
        .req   (req),
        .ptr   (ptr_q),
        .mode  (ModeRr),
        .idx   (win_idx),
        .found (win_found),
        .multi (win_multi)
    );

    // Next-state: capture when idle or when the held result is accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        multi_d = multi_q;
        capture = 1'b0;
        case (state_q)
            StIdle:  capture = win_found;
            StHold:  capture = out_ready && win_found;
            default: capture = 1'b0;
        endcase
        if (capture) begin
            state_d = StHold;
            idx_d   = win_idx;
            multi_d = win_multi;
            if (ModeRr) begin
                ptr_d = (win_idx == '0) ? PtrInit : win_idx - W'(1);
            end
        end else if (state_q == StHold && out_ready) begin
            state_d = StIdle;
        end
    end

    // State registers; reset drops any pending result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= PtrInit;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            multi_q <= multi_d;
        end
    end

    // Outputs: grant is the one-hot of the held index only while valid.
    always_comb begin
        out_valid = (state_q == StHold);
        out_idx   = idx_q;
        multi     = multi_q;
        grant     = '0;
        if (state_q == StHold) begin
            grant[idx_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_cod_prioridade_rr.sv
// Directed bench: one fixed-priority and one round-robin instance on shared stimulus.
module tb_cod_prioridade_rr;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         out_ready;

    logic         valid0, valid1;
    logic [W-1:0] idx0, idx1;
    logic [N-1:0] grant0, grant1;
    logic         multi0, multi1;

    int checks = 0;
    int errors = 0;

    cod_prioridade_rr #(
        .N    (N),
        .MODE (0)
    ) dut_fix (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (valid0),
        .out_idx   (idx0),
        .grant     (grant0),
        .multi     (multi0)
    );

    cod_prioridade_rr #(
        .N    (N),
        .MODE (1)
    ) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (valid1),
        .out_idx   (idx1),
        .grant     (grant1),
        .multi     (multi1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fix(input string tag, input logic v, input logic [W-1:0] i,
                             input logic [N-1:0] g, input logic m);
        check({tag, " fix valid"}, 32'(valid0), 32'(v));
        check({tag, " fix idx"},   32'(idx0),   32'(i));
        check({tag, " fix grant"}, 32'(grant0), 32'(g));
        check({tag, " fix multi"}, 32'(multi0), 32'(m));
    endtask

    task automatic check_rr(input string tag, input logic v, input logic [W-1:0] i,
                            input logic [N-1:0] g, input logic m);
        check({tag, " rr valid"}, 32'(valid1), 32'(v));
        check({tag, " rr idx"},   32'(idx1),   32'(i));
        check({tag, " rr grant"}, 32'(grant1), 32'(g));
        check({tag, " rr multi"}, 32'(multi1), 32'(m));
    endtask

    logic [W-1:0] rr_seq [4];

    initial begin
        rst       = 1'b1;
        req       = 8'h00;
        out_ready = 1'b1;
        #2;
        check_fix("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        check_rr("reset", 1'b0, 3'd0, 8'h00, 1'b0);

        // Requests while in reset must not be captured.
        req = 8'h80;
        tick();
        check_fix("in reset", 1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;

        // Single request at the top index, one cycle latency.
        tick();
        check_fix("single 80", 1'b1, 3'd7, 8'h80, 1'b0);
        check_rr("single 80", 1'b1, 3'd7, 8'h80, 1'b0);

        // Handshake with no request left goes idle, index retained.
        req = 8'h00;
        tick();
        check_fix("drain", 1'b0, 3'd7, 8'h00, 1'b0);
        check("drain rr valid", 32'(valid1), 32'd0);
        check("drain rr grant", 32'(grant1), 32'd0);

        // Held 05: fixed gives 2 every cycle; rr (ptr=6) alternates 2,0,2,0.
        req       = 8'h05;
        rr_seq[0] = 3'd2;
        rr_seq[1] = 3'd0;
        rr_seq[2] = 3'd2;
        rr_seq[3] = 3'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_fix($sformatf("hold05 c%0d", c), 1'b1, 3'd2, 8'h04, 1'b1);
            check_rr($sformatf("hold05 c%0d", c), 1'b1, rr_seq[c],
                     (rr_seq[c] == 3'd2) ? 8'h04 : 8'h01, 1'b1);
        end

        // Capture 7, then stall while req moves to 01.
        req = 8'h80;
        tick();
        check_fix("pre stall", 1'b1, 3'd7, 8'h80, 1'b0);
        check_rr("pre stall", 1'b1, 3'd7, 8'h80, 1'b0);
        out_ready = 1'b0;
        req       = 8'h01;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_fix($sformatf("stall c%0d", c), 1'b1, 3'd7, 8'h80, 1'b0);
            check_rr($sformatf("stall c%0d", c), 1'b1, 3'd7, 8'h80, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check_fix("after stall", 1'b1, 3'd0, 8'h01, 1'b0);
        check_rr("after stall", 1'b1, 3'd0, 8'h01, 1'b0);

        // Asynchronous reset between edges while holding.
        out_ready = 1'b0;
        tick();
        check("pre rst valid", 32'(valid1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_fix("async rst", 1'b0, 3'd0, 8'h00, 1'b0);
        check_rr("async rst", 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        rst       = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        tick();
        check_fix("post rst FF", 1'b1, 3'd7, 8'h80, 1'b1);
        check_rr("post rst FF", 1'b1, 3'd7, 8'h80, 1'b1);
        tick();
        check_fix("FF again", 1'b1, 3'd7, 8'h80, 1'b1);
        check_rr("FF again", 1'b1, 3'd6, 8'h40, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
